sha_sigma_pipe: RTL

- Parametrised, pipelined SHA-2 sigma engine; generalises the fixed 32-bit combinational Sigma0 used by compression.
- Computes any of Σ0, Σ1, σ0, σ1 for SHA-256 (32-bit) or SHA-512 (64-bit) words, selected per transaction.
- Valid/ready handshake on both sides, with full backpressure support.
- Sits between the message scheduler / compression round datapath and the round-word registers, and carries an opaque tag for reordering-free tracking.

---
 rtl/sha_sigma_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sha_sigma_pipe.sv
// Pipelined SHA-2 sigma engine (Σ0/Σ1/σ0/σ1, 32- or 64-bit words) with valid/ready flow control.
// Optional result/stall performance counters are built when SHA_SIGMA_PERF_CNT_EN is defined.
module sha_sigma_pipe #(
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [WORD_W-1:0] in_x,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef SHA_SIGMA_PERF_CNT_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_results,
  output logic [31:0]       perf_stalls
`endif
);

  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("sha_sigma_pipe: WORD_W must be 32 or 64");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("sha_sigma_pipe: PIPE_STAGES must be in 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("sha_sigma_pipe: TAG_W must be at least 1");
  end

  localparam bit          IS64  = (WORD_W == 64);
  localparam int unsigned BS0_A = IS64 ? 28 : 2;
  localparam int unsigned BS0_B = IS64 ? 34 : 13;
  localparam int unsigned BS0_C = IS64 ? 39 : 22;
  localparam int unsigned BS1_A = IS64 ? 14 : 6;
  localparam int unsigned BS1_B = IS64 ? 18 : 11;
  localparam int unsigned BS1_C = IS64 ? 41 : 25;
  localparam int unsigned SS0_A = IS64 ? 1  : 7;
  localparam int unsigned SS0_B = IS64 ? 8  : 18;
  localparam int unsigned SS0_S = IS64 ? 7  : 3;
  localparam int unsigned SS1_A = IS64 ? 19 : 17;
  localparam int unsigned SS1_B = IS64 ? 61 : 19;
  localparam int unsigned SS1_S = IS64 ? 6  : 10;

  // Stage 0 holds the raw operand; stages 1.. hold finished results.
  logic [PIPE_STAGES-1:0] v_q;
  logic [1:0]             mode_q;
  logic [WORD_W-1:0]      d_q   [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] rdy_c;
  logic [WORD_W-1:0]      fn_c;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Sigma function evaluated from the stage-0 operand register.
  always_comb begin
    fn_c = '0;
    case (mode_q)
      2'b00: fn_c = rotr(d_q[0], BS0_A) ^ rotr(d_q[0], BS0_B) ^ rotr(d_q[0], BS0_C);
      2'b01: fn_c = rotr(d_q[0], BS1_A) ^ rotr(d_q[0], BS1_B) ^ rotr(d_q[0], BS1_C);
      2'b10: fn_c = rotr(d_q[0], SS0_A) ^ rotr(d_q[0], SS0_B) ^ (d_q[0] >> SS0_S);
      2'b11: fn_c = rotr(d_q[0], SS1_A) ^ rotr(d_q[0], SS1_B) ^ (d_q[0] >> SS1_S);
      default: fn_c = '0;
    endcase
  end

  // Ready ripples back from the output: a stage can load if empty or draining.
  always_comb begin
    logic r;
    r     = out_ready;
    rdy_c = '0;
    for (int k = int'(PIPE_STAGES) - 1; k >= 0; k--) begin
      r        = !v_q[k] || r;
      rdy_c[k] = r;
    end
  end

  assign in_ready = rdy_c[0] && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      mode_q <= '0;
      for (int k = 0; k < int'(PIPE_STAGES); k++) begin
        d_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      if (rdy_c[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          mode_q   <= in_mode;
          d_q[0]   <= in_x;
          tag_q[0] <= in_tag;
        end
      end
      for (int k = 1; k < int'(PIPE_STAGES); k++) begin
        if (rdy_c[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            d_q[k]   <= (k == 1) ? fn_c : d_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = v_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign out_data  = (PIPE_STAGES == 1) ? fn_c : d_q[PIPE_STAGES-1];

`ifdef SHA_SIGMA_PERF_CNT_EN
  // Saturating counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_results <= '0;
      perf_stalls  <= '0;
    end else if (perf_clr) begin
      perf_results <= '0;
      perf_stalls  <= '0;
    end else begin
      if (out_valid && out_ready && (perf_results != 32'hFFFF_FFFF)) begin
        perf_results <= perf_results + 32'd1;
      end
      if (out_valid && !out_ready && (perf_stalls != 32'hFFFF_FFFF)) begin
        perf_stalls <= perf_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
